// File: rtl/jtopl_reg_sched.sv
// CPU register write scheduler: 4-entry in-order FIFO that releases each write
// when the slot counter reaches the owning slot (globals release at the next cen).
module jtopl_reg_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [1:0] group,
  input  logic [2:0] subslot,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic       ready,
  output logic       upd,
  output logic       upd_global,
  output logic [7:0] upd_addr,
  output logic [7:0] upd_din,
  output logic       ovf
);

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] din;
    logic [1:0] grp;
    logic [2:0] sub;
    logic       glb;
  } entry_t;

  entry_t     mem [4];
  entry_t     new_entry;
  entry_t     head;
  logic [1:0] rd_ptr, wr_ptr;
  logic [2:0] count;
  logic       full, dec_op, dec_ch, dec_gl, valid, hit, push, pop;

  // Operator offsets: bits [4:3] pick the group, bits [2:0] the subslot.
  // Channel registers target the modulator slot of channel c: {c/3, c%3}.
  always_comb begin
    dec_op = (addr[7:5] inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7})
             && (addr[2:0] <= 3'd5) && (addr[4:3] <= 2'd2);
    dec_ch = (addr[7:4] inside {4'hA, 4'hB, 4'hC}) && (addr[3:0] <= 4'd8);
    dec_gl = addr inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h08, 8'hBD};
    valid  = dec_op || dec_ch || dec_gl;

    new_entry      = '0;
    new_entry.addr = addr;
    new_entry.din  = din;
    new_entry.glb  = dec_gl;
    if (dec_op) begin
      new_entry.grp = addr[4:3];
      new_entry.sub = addr[2:0];
    end else if (dec_ch) begin
      new_entry.grp = 2'(addr[3:0] / 4'd3);
      new_entry.sub = 3'(addr[3:0] % 4'd3);
    end
  end

  always_comb begin
    full  = count[2];
    ready = !full && !rst;
    head  = mem[rd_ptr];
    hit   = (count != 3'd0) && (head.glb || (head.grp == group && head.sub == subslot));
    pop   = cen && hit;
    push  = wr && ready && valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      upd        <= 1'b0;
      upd_global <= 1'b0;
      upd_addr   <= '0;
      upd_din    <= '0;
      ovf        <= 1'b0;
    end else begin
      upd <= pop;
      if (pop) begin
        upd_global <= head.glb;
        upd_addr   <= head.addr;
        upd_din    <= head.din;
        rd_ptr     <= rd_ptr + 2'd1;
      end
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      count <= count + 3'(push) - 3'(pop);
      if (wr && full && valid) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtopl_reg_sched.sv
// Directed bench for jtopl_reg_sched: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_jtopl_reg_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic [1:0] group = 2'd0;
  logic [2:0] subslot = 3'd0;
  logic       wr = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic       ready, upd, upd_global, ovf;
  logic [7:0] upd_addr, upd_din;

  jtopl_reg_sched dut (
    .clk(clk), .rst(rst), .cen(cen), .group(group), .subslot(subslot),
    .wr(wr), .addr(addr), .din(din), .ready(ready), .upd(upd),
    .upd_global(upd_global), .upd_addr(upd_addr), .upd_din(upd_din), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: address map by ranges, pending writes in a queue.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         g;
    int         s;
    bit         glob;
  } ent_t;

  ent_t       q[$];
  ent_t       me;
  logic       m_upd = 1'b0, m_glob = 1'b0, m_ovf = 1'b0;
  logic [7:0] m_addr = 8'h00, m_din = 8'h00;
  int         m_pre, mg, ms;
  bit         mgl;

  function automatic bit decode(input logic [7:0] a, output int g, output int s, output bit glob);
    int ob[5] = '{32, 64, 96, 128, 224};
    int cb[3] = '{160, 176, 192};
    int off;
    g = 0; s = 0; glob = 0;
    if (a == 8'h01 || a == 8'h02 || a == 8'h03 || a == 8'h04 || a == 8'h08 || a == 8'hBD) begin
      glob = 1;
      return 1;
    end
    for (int k = 0; k < 5; k++)
      if (int'(a) >= ob[k] && int'(a) <= ob[k] + 21) begin
        off = int'(a) - ob[k];
        if (off % 8 > 5) return 0;
        g = off / 8;
        s = off % 8;
        return 1;
      end
    for (int k = 0; k < 3; k++)
      if (int'(a) >= cb[k] && int'(a) <= cb[k] + 8) begin
        off = int'(a) - cb[k];
        g = off / 3;
        s = off % 3;
        return 1;
      end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_upd = 0; m_glob = 0; m_addr = 0; m_din = 0; m_ovf = 0;
    end else begin
      m_pre = q.size();
      m_upd = 0;
      if (cen && m_pre > 0 && (q[0].glob || (q[0].g == int'(group) && q[0].s == int'(subslot)))) begin
        m_upd  = 1;
        m_glob = q[0].glob;
        m_addr = q[0].a;
        m_din  = q[0].d;
        void'(q.pop_front());
      end
      if (wr && decode(addr, mg, ms, mgl)) begin
        if (m_pre < 4) begin
          me.a = addr; me.d = din; me.g = mg; me.s = ms; me.glob = mgl;
          q.push_back(me);
        end else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("upd", upd, m_upd);
    chk("upd_global", upd_global, m_glob);
    chk("upd_addr", upd_addr, m_addr);
    chk("upd_din", upd_din, m_din);
    chk("ready", ready, (!rst && q.size() < 4));
    chk("ovf", ovf, m_ovf);
  end

  // Stimulus: inputs change 1 time unit after the rising edge.
  task automatic tick(input logic c);
    cen = c;
    @(posedge clk);
    #1;
    wr  = 1'b0;
    cen = 1'b0;
    if (c) begin
      if (subslot == 3'd5) begin
        subslot = 3'd0;
        group   = (group == 2'd2) ? 2'd0 : group + 2'd1;
      end else subslot = subslot + 3'd1;
    end
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    wr   = 1'b1;
    tick(1'b0);
  endtask

  task automatic goto_slot(input logic [1:0] g, input logic [2:0] s);
    for (int i = 0; i < 18 && !(group == g && subslot == s); i++) tick(1'b1);
  endtask

  task automatic run_count(input int n, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1'b1);
      if (upd) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
  endtask

  int cnt, first, p35, pbd, gbd;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_rst", ready, 0);
    chk("upd_in_rst", upd, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ready, 1);
    chk("ovf_after_rst", ovf, 0);
    chk("upd_addr_after_rst", upd_addr, 0);

    // Operator write issues on the first cen edge at slot {0,0}
    write(8'h40, 8'h3F);
    chk("op_ready", ready, 1);
    tick(1'b1);
    chk("op_upd", upd, 1);
    chk("op_addr", upd_addr, 8'h40);
    chk("op_din", upd_din, 8'h3F);
    chk("op_glob", upd_global, 0);

    // Channel 5 from slot {1,3}: issues on the 18th cen pulse
    goto_slot(2'd1, 3'd3);
    write(8'hA5, 8'h12);
    run_count(20, cnt, first);
    chk("ch_count", cnt, 1);
    chk("ch_pulse", first, 18);
    chk("ch_addr", upd_addr, 8'hA5);
    chk("ch_din", upd_din, 8'h12);

    // Global behind a pending operator write waits for it
    goto_slot(2'd0, 3'd0);
    write(8'h35, 8'h11);
    write(8'hBD, 8'h20);
    p35 = 0; pbd = 0; gbd = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1);
      if (upd && upd_addr == 8'h35) p35 = i;
      if (upd && upd_addr == 8'hBD) begin pbd = i; gbd = upd_global; end
    end
    chk("hol_op_pulse", p35, 18);
    chk("hol_glb_pulse", pbd, 19);
    chk("hol_glb_flag", gbd, 1);

    // Fill, overflow, then drain
    for (int i = 0; i < 5; i++) begin
      write(8'h20, 8'(i));
      if (i == 2) chk("fill3_ready", ready, 1);
      if (i == 3) begin chk("fill4_ready", ready, 0); chk("fill4_ovf", ovf, 0); end
      if (i == 4) chk("fill5_ovf", ovf, 1);
    end
    run_count(80, cnt, first);
    chk("drain_count", cnt, 4);
    chk("drain_last_din", upd_din, 8'h03);
    chk("drain_ready", ready, 1);

    rst = 1'b1;
    #2;
    chk("ovf_clear", ovf, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Invalid addresses are ignored; 0x50 targets {2,0}
    write(8'h26, 8'h01);
    write(8'hA9, 8'h02);
    chk("inv_ovf", ovf, 0);
    chk("inv_ready", ready, 1);
    write(8'h50, 8'h33);
    run_count(40, cnt, first);
    chk("inv_count", cnt, 1);
    chk("inv_addr", upd_addr, 8'h50);
    chk("inv_din", upd_din, 8'h33);

    // Reset with pending entries while upd is high
    goto_slot(2'd0, 3'd0);
    write(8'h20, 8'hA1);
    write(8'h55, 8'hA2);
    write(8'h75, 8'hA3);
    write(8'h95, 8'hA4);
    write(8'h20, 8'hA5);
    chk("rs_ovf_set", ovf, 1);
    tick(1'b1);
    chk("rs_upd_pre", upd, 1);
    chk("rs_addr_pre", upd_addr, 8'h20);
    rst = 1'b1;
    #1;
    chk("rs_upd", upd, 0);
    chk("rs_ready", ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rs_ready_rel", ready, 1);
    chk("rs_ovf_rel", ovf, 0);
    run_count(36, cnt, first);
    chk("rs_stale", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtopl_reg_sched.md
# jtopl_reg_sched

Write scheduler between the CPU register port and the per-slot register chain of the OPL core. Accepted writes go into a 4-entry in-order FIFO. Each operator or channel write is held until the slot counter presents the slot that owns it, then issued as a one-cycle update strobe. Global register writes issue at the first `cen` once they reach the FIFO head.

## Interface
- No parameters; FIFO depth fixed at 4.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `cen` in 1: clock enable, same enable that advances the slot counter.
- `group` in 2: current group from the slot counter (0..2).
- `subslot` in 3: current subslot from the slot counter (0..5).
- `wr` in 1: CPU write request, sampled every `clk`, independent of `cen`.
- `addr` in 8: register address.
- `din` in 8: register data.
- `ready` out 1: FIFO can accept; `!full && !rst`.
- `upd` out 1: one-`clk` update strobe.
- `upd_global` out 1: the issued write targets a global register.
- `upd_addr` out 8: address of the issued write.
- `upd_din` out 8: data of the issued write.
- `ovf` out 1: sticky; set when `wr` arrives with `ready`=0.

## Operation
Address decode happens at push. Each accepted write is stored as {addr, din, tgt_group, tgt_sub, global}.
- **Operator registers** 0x20–0x35, 0x40–0x55, 0x60–0x75, 0x80–0x95, 0xE0–0xF5.
  - o = addr[4:0]; valid only if o[2:0] ≤ 5 and o[4:3] ≤ 2.
  - tgt_group = o[4:3], tgt_sub = o[2:0].
- **Channel registers** 0xA0–0xA8, 0xB0–0xB8, 0xC0–0xC8.
  - c = addr[3:0] ≤ 8.
  - tgt_group = c/3, tgt_sub = c%3 (modulator slot of that channel).
- **Global registers** 0x01, 0x02, 0x03, 0x04, 0x08, 0xBD: global=1, target ignored.
- Any other address is not enqueued: no push, no flag, `ready` unchanged.
- The FIFO is strict in order. Only the head can issue, and a pending head blocks all later entries, including globals.
- Head matches when global=1, or when {tgt_group, tgt_sub} equals the current {group, subslot}.
- On a `clk` edge with `cen`=1 and a matching head:
  - `upd`<=1, `upd_global`/`upd_addr`/`upd_din` <= head fields;
  - pop the head.
- On every other edge `upd`<=0. The `upd_*` fields hold their last value.
- At most one issue per `cen`.
- Push and pop in the same edge are allowed. Occupancy stays the same and order is kept.
- While full, `ready`=0. The `wr` is dropped and `ovf`<=1.
- `ovf` clears only on `rst`.

## Timing
- Reset values: FIFO empty, `upd`=0, `upd_global`=0, `upd_addr`=0, `upd_din`=0, `ovf`=0.
- `ready` is 0 while `rst` is high and 1 after release.
- `rst` mid-operation discards all pending entries immediately. No `upd` is produced for them.
- Push: `wr` && `ready` at edge N makes the entry visible as head at edge N+1 (if the FIFO was empty). The earliest `upd` is edge N+1, high during cycle N+1..N+2.
- Slot match uses the pre-edge `group`/`subslot`. In the cycle `upd` is high, the counter already shows the next slot; downstream latches with that one-slot offset.
- Worst-case issue latency for a head entry: 18 `cen` pulses (one full slot rotation).
- Slot counter wrap (group 2/subslot 5 → 0/0) needs no special handling; matching is purely by value.
- `cen`=0: no issue and no counter comparison; pushes still occur.

## Test plan
- **Operator write.** After reset, counter at {0,0}: write 0x40 ← 0x3F.
  - Expect `upd`=1 on the first `cen` edge with counter {0,0}, with `upd_addr`=0x40, `upd_din`=0x3F, `upd_global`=0.
  - Expect `ready`=1 throughout.
- **Channel write.** Write 0xA5 ← 0x12 (channel 5 → target {1,2}) while the counter is at {1,3}.
  - Expect no `upd` for 17 `cen` pulses.
  - Expect `upd` on the 18th, at {1,2}.
- **Head-of-line blocking.** Write 0x35 (target {2,5}) then 0xBD ← 0x20 with the counter at {0,0}.
  - Expect 0xBD issued exactly one `cen` after 0x35, never before it.
- **Full and overflow.** Five writes to 0x20 with `cen`=0.
  - Expect `ready`=0 after the fourth and `ovf`=1 after the fifth.
  - Expect exactly four `upd` pulses once `cen` resumes.
- **Invalid addresses.** Writes to 0x26, 0xA9 and 0x50.
  - 0x26 and 0xA9: not enqueued, no `upd`, `ovf` stays 0.
  - 0x50 is valid (target {2,0}) and issues.
- **Reset mid-operation.** Assert `rst` with 3 pending entries.
  - Expect `ready`=0 and `upd`=0 immediately.
  - After release: `ready`=1, `ovf`=0, no stale `upd` over 36 `cen` pulses.
